cv_mem_mapper: RTL

Parametrised, registered successor to the ColecoVision address decoder. It owns all memory-map state: MegaCart bank register, SGM BIOS/RAM switches and ADAM lower/upper memory configuration. It produces one region select, a chip enable and a physical address for the 64K Z80 space. It sits between the Z80 bus and the SDRAM/BRAM arbiters. I/O device decoding (VDP, PSG, controllers) stays in the existing decoder.

---
 rtl/cv_mapper_pkg.sv | 27 ++
 rtl/cv_bus_edge.sv | 19 +
 rtl/cv_mem_mapper.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/cv_mapper_pkg.sv
// Shared types and constants for the ColecoVision memory mapper.
// Region and mode encodings match the cfg and region bus values seen by the arbiters.
package cv_mapper_pkg;

  typedef enum logic [2:0] {
    REGION_NONE    = 3'd0,
    REGION_BIOS    = 3'd1,
    REGION_RAM     = 3'd2,
    REGION_CART    = 3'd3,
    REGION_EOS     = 3'd4,
    REGION_WRITER  = 3'd5,
    REGION_EXP_RAM = 3'd6,
    REGION_EXP_ROM = 3'd7
  } region_t;

  typedef enum logic [1:0] {
    MODE_COLECO = 2'd0,
    MODE_SGM    = 2'd1,
    MODE_ADAM   = 2'd2,
    MODE_SG1000 = 2'd3
  } mode_t;

  localparam logic [7:0] PORT_MEMCFG  = 8'h7F;
  localparam logic [7:0] PORT_SGM     = 8'h53;
  localparam logic [9:0] HOTSPOT_BASE = 10'h3FF;

endpackage

// File: rtl/cv_bus_edge.sv
// Registers a bus strobe and flags its first active cycle, so a strobe held
// for many clocks still produces exactly one start pulse.
module cv_bus_edge (
  input  logic clk,
  input  logic reset_n,
  input  logic strobe,
  output logic start
);

  logic strobe_q;

  always_ff @(posedge clk) begin
    if (!reset_n) strobe_q <= 1'b0;
    else          strobe_q <= strobe;
  end

  assign start = strobe & ~strobe_q;

endmodule

// File: rtl/cv_mem_mapper.sv
// ColecoVision/SGM/ADAM/SG1000 memory mapper: owns all banking state and
// decodes each Z80 memory access into a region, chip enable and physical address.
module cv_mem_mapper
  import cv_mapper_pkg::*;
#(
  parameter int CART_PAGE_BITS = 6,
  parameter int EXP_PAGE_BITS  = 2,
  parameter int PHYS_AW        = 22
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic [1:0]                mode_i,
  input  logic [CART_PAGE_BITS-1:0] cart_pages_i,
  input  logic [15:0]               a_i,
  input  logic [7:0]                d_i,
  input  logic                      mreq_n_i,
  input  logic                      iorq_n_i,
  input  logic                      rd_n_i,
  input  logic                      wr_n_i,
  input  logic                      rfsh_n_i,
  output logic [2:0]                region_o,
  output logic                      ce_n_o,
  output logic [PHYS_AW-1:0]        phys_addr_o,
  input  logic [EXP_PAGE_BITS-1:0]  exp_page_i,
  output logic                      page_upd_o,
  output logic [7:0]                cfg_o
);

  logic mem_acc, io_wr, mem_start, io_start;

  assign mem_acc = ~mreq_n_i & rfsh_n_i & (~rd_n_i | ~wr_n_i);
  assign io_wr   = ~iorq_n_i & mreq_n_i & ~wr_n_i;

  cv_bus_edge u_mem_edge (
    .clk     (clk_i),
    .reset_n (reset_n_i),
    .strobe  (mem_acc),
    .start   (mem_start)
  );

  cv_bus_edge u_io_edge (
    .clk     (clk_i),
    .reset_n (reset_n_i),
    .strobe  (io_wr),
    .start   (io_start)
  );

  mode_t                     mode_q;
  logic [CART_PAGE_BITS-1:0] megacart_page;
  logic                      bios_en, sgm_ram, page_upd;
  logic [1:0]                lower_mem, upper_mem;
  logic                      megacart_en, hotspot_hit;
  logic [CART_PAGE_BITS-1:0] mask_inc;

  // A contiguous low mask plus one has no bits in common with the mask.
  assign mask_inc    = cart_pages_i + CART_PAGE_BITS'(1);
  assign megacart_en = (mode_q != MODE_SG1000) &&
                       ((cart_pages_i & mask_inc) == '0) &&
                       (cart_pages_i > CART_PAGE_BITS'(1));

  assign hotspot_hit = mem_start && !rd_n_i && megacart_en && (a_i[15:6] == HOTSPOT_BASE);

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      mode_q        <= mode_t'(mode_i);
      megacart_page <= '0;
      bios_en       <= 1'b1;
      sgm_ram       <= 1'b0;
      page_upd      <= 1'b0;
      if (mode_t'(mode_i) == MODE_ADAM) begin
        lower_mem <= 2'b00;
        upper_mem <= 2'b00;
      end else begin
        lower_mem <= 2'b11;
        upper_mem <= 2'b11;
      end
    end else begin
      page_upd <= 1'b0;
      if (hotspot_hit) begin
        megacart_page <= CART_PAGE_BITS'(a_i[5:0]) & cart_pages_i;
        page_upd      <= 1'b1;
      end
      if (io_start && a_i[7:0] == PORT_MEMCFG) begin
        case (mode_q)
          MODE_COLECO, MODE_SGM: begin
            bios_en  <= d_i[1];
            page_upd <= 1'b1;
          end
          MODE_ADAM: begin
            lower_mem <= d_i[1:0];
            upper_mem <= d_i[3:2];
            page_upd  <= 1'b1;
          end
          default: ;
        endcase
      end
      if (io_start && a_i[7:0] == PORT_SGM && mode_q == MODE_SGM) begin
        sgm_ram  <= d_i[0];
        page_upd <= 1'b1;
      end
    end
  end

  logic                      lower_coleco, upper_coleco;
  logic [CART_PAGE_BITS-1:0] cart_page;
  region_t                   region;
  logic [PHYS_AW-1:0]        phys;

  assign lower_coleco = (mode_q != MODE_ADAM) || (lower_mem == 2'b11);
  assign upper_coleco = (mode_q != MODE_ADAM) || (upper_mem == 2'b11);
  assign cart_page    = a_i[14] ? (megacart_en ? megacart_page : CART_PAGE_BITS'(1))
                                : (megacart_en ? cart_pages_i  : '0);

  always_comb begin
    region = REGION_NONE;
    phys   = '0;
    if (mem_acc) begin
      if (mode_q == MODE_SG1000) begin
        if (a_i[15:14] == 2'b11) begin
          region = REGION_RAM;
          phys   = PHYS_AW'(a_i[9:0]);
        end else begin
          region = REGION_CART;
          phys   = PHYS_AW'(a_i);
        end
      end else if (!a_i[15]) begin
        if (!lower_coleco) begin
          case (lower_mem)
            2'b01: begin
              region = REGION_RAM;
              phys   = PHYS_AW'(a_i[14:0]);
            end
            2'b00: begin
              region = REGION_WRITER;
              phys   = PHYS_AW'(a_i[14:0]);
            end
            default: ;
          endcase
        end else if (a_i[14:13] == 2'b00) begin
          if (bios_en) begin
            region = REGION_BIOS;
            phys   = PHYS_AW'(a_i[12:0]);
          end else if (sgm_ram) begin
            region = REGION_RAM;
            phys   = PHYS_AW'(a_i[14:0]);
          end
        end else if (sgm_ram) begin
          region = REGION_RAM;
          phys   = PHYS_AW'(a_i[14:0]);
        end else if (a_i[14:13] == 2'b11) begin
          region = REGION_RAM;
          phys   = PHYS_AW'(a_i[9:0]);
        end
      end else if (upper_coleco) begin
        region = REGION_CART;
        phys   = PHYS_AW'({cart_page, a_i[13:0]});
      end else begin
        case (upper_mem)
          2'b10: begin
            region = REGION_EXP_RAM;
            phys   = PHYS_AW'({exp_page_i, a_i[14:0]});
          end
          2'b01: begin
            region = REGION_EXP_ROM;
            phys   = PHYS_AW'(a_i[14:0]);
          end
          default: begin
            region = REGION_RAM;
            phys   = PHYS_AW'({1'b1, a_i[14:0]});
          end
        endcase
      end
    end
  end

  logic unused_d;
  assign unused_d = ^d_i[7:4];

  assign region_o    = region;
  assign ce_n_o      = (region == REGION_NONE);
  assign phys_addr_o = phys;
  assign page_upd_o  = page_upd;
  assign cfg_o       = {upper_mem, lower_mem, sgm_ram, bios_en, megacart_en, 1'b0};

endmodule
